// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Pipeline control for a 4-stage (ID/EX/MEM/WB) datapath. Decodes the ID-stage
// opcode into a control word, carries control words and register addresses
// through the EX/MEM/WB registers, detects load-use hazards and branch
// flushes, and selects the forwarding source for both EX operands.
//
// Control word layout (id_ctrl / ex_ctrl / mem_ctrl / wb_ctrl):
//   [7] regWrite  [6] memRead  [5] memWrite  [4] branch  [3] MemToReg  [2:0] OP
//
// Forward select encoding: 2'b00 none, 2'b01 from WB, 2'b10 from MEM.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous, active-high
//   id_valid        ID stage holds a real instruction
//   id_opcode       opcode of the ID instruction
//   id_rs, id_rt    ID source registers
//   id_rd           ID destination register
//   ex_branch_taken branch in EX resolved taken; squash the instruction in ID
//   id_ctrl         combinational decode of the ID instruction
//   stall           hold PC and IF/ID, insert a bubble into EX
//   ex_ctrl, mem_ctrl, wb_ctrl   registered per-stage control words
//   ex_rd, mem_rd, wb_rd         registered per-stage destination registers
//   fwd_a, fwd_b    forward select for the EX rs / rt operand
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [2:0]            id_opcode,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  ex_branch_taken,
    output logic [7:0]            id_ctrl,
    output logic                  stall,
    output logic [7:0]            ex_ctrl,
    output logic [7:0]            mem_ctrl,
    output logic [7:0]            wb_ctrl,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b
);

    typedef enum logic [2:0] {
        AND_OP = 3'd0,
        XOR_OP = 3'd1,
        SHL_OP = 3'd2,
        SHR_OP = 3'd3,
        ADD_OP = 3'd4,
        LW_OP  = 3'd5,
        SW_OP  = 3'd6,
        BR_OP  = 3'd7
    } opcode_t;

    localparam logic [1:0] FORWARD_NONE = 2'b00;
    localparam logic [1:0] FORWARD_WB   = 2'b01;
    localparam logic [1:0] FORWARD_MEM  = 2'b10;

    localparam int REGWRITE = 7;
    localparam int MEMREAD  = 6;
    localparam int MEMWRITE = 5;
    localparam int BRANCH   = 4;
    localparam int MEMTOREG = 3;

    logic [7:0]            r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
    logic [REG_ADDR_W-1:0] r_ex_rd, r_mem_rd, r_wb_rd;
    logic [REG_ADDR_W-1:0] r_ex_rs, r_ex_rt;

    logic [7:0] w_id_ctrl;
    logic       w_uses_rt;
    logic       w_load_use;
    logic       w_ex_bubble;

    // ID decode
    always_comb begin
        w_id_ctrl = '0;
        if (id_valid) begin
            w_id_ctrl[2:0] = id_opcode;
            case (opcode_t'(id_opcode))
                AND_OP, XOR_OP, SHL_OP, SHR_OP, ADD_OP: w_id_ctrl[REGWRITE] = 1'b1;
                LW_OP: begin
                    w_id_ctrl[REGWRITE] = 1'b1;
                    w_id_ctrl[MEMREAD]  = 1'b1;
                    w_id_ctrl[MEMTOREG] = 1'b1;
                end
                SW_OP:   w_id_ctrl[MEMWRITE] = 1'b1;
                BR_OP:   w_id_ctrl[BRANCH]   = 1'b1;
                default: w_id_ctrl = '0;
            endcase
        end
    end

    // A load only reads its base register; every other opcode reads both.
    assign w_uses_rt  = (id_opcode != LW_OP);
    assign w_load_use = r_ex_ctrl[MEMREAD] && id_valid &&
                        ((r_ex_rd == id_rs) || (w_uses_rt && (r_ex_rd == id_rt)));

    // A taken branch squashes the ID instruction, so any hazard it had is moot.
    assign w_ex_bubble = w_load_use || ex_branch_taken;
    assign stall       = w_load_use && !ex_branch_taken;

    // ID -> EX -> MEM -> WB; MEM and WB never stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_ctrl  <= '0;
            r_mem_ctrl <= '0;
            r_wb_ctrl  <= '0;
            r_ex_rd    <= '0;
            r_mem_rd   <= '0;
            r_wb_rd    <= '0;
            r_ex_rs    <= '0;
            r_ex_rt    <= '0;
        end else begin
            r_ex_ctrl  <= w_ex_bubble ? 8'h00 : w_id_ctrl;
            r_ex_rd    <= id_rd;
            r_ex_rs    <= id_rs;
            r_ex_rt    <= id_rt;
            r_mem_ctrl <= r_ex_ctrl;
            r_mem_rd   <= r_ex_rd;
            r_wb_ctrl  <= r_mem_ctrl;
            r_wb_rd    <= r_mem_rd;
        end
    end

    // Loaded data is not available in MEM, so a load there never forwards;
    // the load-use stall pushes that case into WB.
    function automatic logic [1:0] fwd_select(input logic [REG_ADDR_W-1:0] src);
        if (r_mem_ctrl[REGWRITE] && !r_mem_ctrl[MEMREAD] && (r_mem_rd == src))
            return FORWARD_MEM;
        else if (r_wb_ctrl[REGWRITE] && (r_wb_rd == src))
            return FORWARD_WB;
        else
            return FORWARD_NONE;
    endfunction

    assign fwd_a    = fwd_select(r_ex_rs);
    assign fwd_b    = fwd_select(r_ex_rt);

    assign id_ctrl  = w_id_ctrl;
    assign ex_ctrl  = r_ex_ctrl;
    assign mem_ctrl = r_mem_ctrl;
    assign wb_ctrl  = r_wb_ctrl;
    assign ex_rd    = r_ex_rd;
    assign mem_rd   = r_mem_rd;
    assign wb_rd    = r_wb_rd;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    localparam int W = 3;

    localparam logic [2:0] AND_OP = 3'd0, XOR_OP = 3'd1, SHL_OP = 3'd2, SHR_OP = 3'd3,
                           ADD_OP = 3'd4, LW_OP = 3'd5, SW_OP = 3'd6, BR_OP = 3'd7;

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid;
    logic [2:0]   id_opcode;
    logic [W-1:0] id_rs, id_rt, id_rd;
    logic         ex_branch_taken;
    logic [7:0]   id_ctrl, ex_ctrl, mem_ctrl, wb_ctrl;
    logic         stall;
    logic [W-1:0] ex_rd, mem_rd, wb_rd;
    logic [1:0]   fwd_a, fwd_b;

    int checks = 0;
    int failures = 0;

    hazard_forward_ctrl #(.REG_ADDR_W(W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .id_ctrl(id_ctrl), .stall(stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl),
        .wb_ctrl(wb_ctrl), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] rs,
                         input logic [W-1:0] rt, input logic [W-1:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drive(1'b0, AND_OP, 0, 0, 0);
        repeat (3) step();
    endtask

    logic [7:0] exp_dec [8];

    initial begin
        exp_dec[0] = 8'h80; exp_dec[1] = 8'h81; exp_dec[2] = 8'h82; exp_dec[3] = 8'h83;
        exp_dec[4] = 8'h84; exp_dec[5] = 8'hCD; exp_dec[6] = 8'h26; exp_dec[7] = 8'h17;

        reset = 1'b1;
        ex_branch_taken = 1'b0;
        drive(1'b0, AND_OP, 0, 0, 0);
        check_eq("rst_ex_ctrl", ex_ctrl, 8'h00);
        check_eq("rst_wb_ctrl", wb_ctrl, 8'h00);
        check_eq("rst_stall", {7'd0, stall}, 8'h00);
        check_eq("idle_id_ctrl", id_ctrl, 8'h00);

        // decode sweep (combinational, pipeline held in reset)
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 0, 0, 0);
            check_eq($sformatf("decode_op%0d", i), id_ctrl, exp_dec[i]);
        end
        drive(1'b0, LW_OP, 0, 0, 0);
        check_eq("decode_invalid", id_ctrl, 8'h00);

        @(negedge clk);
        reset = 1'b0;
        drain();

        // back-to-back ALU with latency
        drive(1'b1, ADD_OP, 2, 3, 1);
        step();
        check_eq("lat_ex", ex_ctrl, 8'h84);
        drive(1'b1, XOR_OP, 1, 4, 2);
        step();
        check_eq("lat_mem", mem_ctrl, 8'h84);
        check_eq("b2b_fwd_a", {6'd0, fwd_a}, 8'h02);
        check_eq("b2b_fwd_b", {6'd0, fwd_b}, 8'h00);
        drive(1'b0, AND_OP, 0, 0, 0);
        step();
        check_eq("lat_wb", wb_ctrl, 8'h84);
        check_eq("lat_wb_rd", {5'd0, wb_rd}, 8'h01);
        drain();

        // one unrelated instruction in between -> WB forward
        drive(1'b1, ADD_OP, 2, 3, 1);
        step();
        drive(1'b1, ADD_OP, 5, 6, 7);
        step();
        drive(1'b1, XOR_OP, 1, 6, 2);
        step();
        check_eq("gap_fwd_a", {6'd0, fwd_a}, 8'h01);
        check_eq("gap_fwd_b", {6'd0, fwd_b}, 8'h00);
        drain();

        // load-use: LW r3; ADD r4,r3,r5
        drive(1'b1, LW_OP, 0, 0, 3);
        step();
        drive(1'b1, ADD_OP, 3, 5, 4);
        check_eq("lu_stall", {7'd0, stall}, 8'h01);
        step();
        check_eq("lu_bubble_ex", ex_ctrl, 8'h00);
        check_eq("lu_mem_lw", mem_ctrl, 8'hCD);
        check_eq("lu_stall_once", {7'd0, stall}, 8'h00);
        step();
        check_eq("lu_add_ex", ex_ctrl, 8'h84);
        check_eq("lu_fwd_a", {6'd0, fwd_a}, 8'h01);
        drain();

        // LW then SW reading rt; LW reading r3 only through rt does not stall
        drive(1'b1, LW_OP, 0, 0, 3);
        step();
        drive(1'b1, SW_OP, 6, 3, 0);
        check_eq("lu_sw_stall", {7'd0, stall}, 8'h01);
        drive(1'b1, LW_OP, 5, 3, 6);
        check_eq("lu_lw_rt_nostall", {7'd0, stall}, 8'h00);
        drive(1'b0, ADD_OP, 3, 3, 6);
        check_eq("lu_invalid_nostall", {7'd0, stall}, 8'h00);
        drain();

        // flush overrides stall
        drive(1'b1, LW_OP, 0, 0, 3);
        step();
        ex_branch_taken = 1'b1;
        drive(1'b1, ADD_OP, 3, 5, 4);
        check_eq("flush_stall", {7'd0, stall}, 8'h00);
        step();
        ex_branch_taken = 1'b0;
        check_eq("flush_ex", ex_ctrl, 8'h00);
        drain();

        // double hazard: MEM wins over WB
        drive(1'b1, ADD_OP, 2, 2, 1);
        step();
        drive(1'b1, ADD_OP, 2, 2, 1);
        step();
        drive(1'b1, XOR_OP, 1, 1, 5);
        step();
        check_eq("dbl_fwd_a", {6'd0, fwd_a}, 8'h02);
        check_eq("dbl_fwd_b", {6'd0, fwd_b}, 8'h02);
        drain();

        // non-writing producers never forward
        drive(1'b1, SW_OP, 2, 4, 1);
        step();
        drive(1'b1, BR_OP, 2, 4, 1);
        step();
        drive(1'b1, ADD_OP, 1, 1, 5);
        step();
        check_eq("nowr_fwd_a", {6'd0, fwd_a}, 8'h00);
        check_eq("nowr_fwd_b", {6'd0, fwd_b}, 8'h00);
        drain();

        // reset mid-stall, asynchronously
        drive(1'b1, ADD_OP, 2, 2, 1);
        step();
        drive(1'b1, LW_OP, 0, 0, 3);
        step();
        drive(1'b1, ADD_OP, 3, 1, 4);
        check_eq("pre_rst_stall", {7'd0, stall}, 8'h01);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_stall", {7'd0, stall}, 8'h00);
        check_eq("arst_ex", ex_ctrl, 8'h00);
        check_eq("arst_mem", mem_ctrl, 8'h00);
        check_eq("arst_fwd_a", {6'd0, fwd_a}, 8'h00);
        check_eq("arst_fwd_b", {6'd0, fwd_b}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, SHL_OP, 1, 2, 3);
        step();
        check_eq("post_rst_ex", ex_ctrl, 8'h82);
        check_eq("post_rst_rd", {5'd0, ex_rd}, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
